// File: rtl/ternary_fetch_unit.sv
// Instruction fetch stage: balanced-ternary PC, combinational imem read address,
// prefetch FIFO toward decode with valid/ready and flush-and-redirect.
package ternary_pkg;
    typedef logic [1:0] trit_t;
    localparam trit_t T_ZERO    = 2'b00;
    localparam trit_t T_POS_ONE = 2'b01;
    localparam trit_t T_NEG_ONE = 2'b10;
    typedef trit_t [7:0] trit8_t;
    typedef trit_t [8:0] trit9_t;
    localparam trit9_t TRIT9_ZERO = '0;
endpackage

module ternary_fetch_unit
    import ternary_pkg::*;
#(
    parameter int IMEM_DEPTH = 243,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_en,
    output trit_t [7:0]                   imem_addr,
    input  trit_t [8:0]                   imem_data,
    input  logic                          redirect_valid,
    input  trit_t [7:0]                   redirect_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output trit_t [8:0]                   instr_data,
    output trit_t [7:0]                   instr_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Invalid trit codes contribute nothing, i.e. they read as zero.
    function automatic int bt_to_int(input trit8_t t);
        int acc;
        int w;
        acc = 0;
        w   = 1;
        for (int i = 0; i < 8; i++) begin
            if (t[i] == T_POS_ONE) acc = acc + w;
            else if (t[i] == T_NEG_ONE) acc = acc - w;
            w = w * 3;
        end
        return acc;
    endfunction

    function automatic trit8_t int_to_bt(input int v);
        trit8_t t;
        int     x;
        int     r;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r = x % 3;
            if (r < 0) r = r + 3;
            if (r == 0) begin
                t[i] = T_ZERO;
                x    = x / 3;
            end else if (r == 1) begin
                t[i] = T_POS_ONE;
                x    = (x - 1) / 3;
            end else begin
                t[i] = T_NEG_ONE;
                x    = (x + 1) / 3;
            end
        end
        return t;
    endfunction

    function automatic trit8_t bt_inc(input trit8_t t);
        trit8_t o;
        logic   carry;
        o     = t;
        carry = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (carry) begin
                if (t[i] == T_POS_ONE) begin
                    o[i] = T_NEG_ONE;
                end else begin
                    o[i]  = (t[i] == T_NEG_ONE) ? T_ZERO : T_POS_ONE;
                    carry = 1'b0;
                end
            end
        end
        return o;
    endfunction

    function automatic trit8_t bt_clean(input trit8_t t);
        trit8_t o;
        for (int i = 0; i < 8; i++)
            o[i] = (t[i] == T_POS_ONE || t[i] == T_NEG_ONE) ? t[i] : T_ZERO;
        return o;
    endfunction

    localparam trit8_t RESET_PC_BT = int_to_bt(RESET_PC);

    trit8_t             pc_reg, pc_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    trit9_t             head_data_reg, head_data_next;
    trit8_t             head_pc_reg, head_pc_next;
    trit9_t             data_mem [FIFO_DEPTH];
    trit8_t             pc_mem   [FIFO_DEPTH];
    logic               pop, push, full;
    int                 redirect_int;

    always_comb begin
        pop            = (count_reg != '0) && instr_ready;
        full           = (count_reg == CNT_W'(FIFO_DEPTH));
        push           = fetch_en && !redirect_valid && (!full || pop);
        redirect_int   = bt_to_int(redirect_pc);
        pc_next        = pc_reg;
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        count_next     = count_reg;
        head_data_next = head_data_reg;
        head_pc_next   = head_pc_reg;
        if (redirect_valid) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
            pc_next     = (redirect_int >= 0 && redirect_int < IMEM_DEPTH) ?
                          bt_clean(redirect_pc) : '0;
        end else begin
            if (pop) rd_ptr_next = rd_ptr_reg + 1'b1;
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
                pc_next     = (bt_to_int(pc_reg) == IMEM_DEPTH - 1) ? '0 : bt_inc(pc_reg);
            end
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
            // Head tracks the oldest surviving entry; a push into an
            // otherwise-empty FIFO bypasses storage so latency stays one cycle.
            if (count_reg > CNT_W'(pop)) begin
                head_data_next = data_mem[rd_ptr_next];
                head_pc_next   = pc_mem[rd_ptr_next];
            end else if (push) begin
                head_data_next = imem_data;
                head_pc_next   = pc_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg        <= RESET_PC_BT;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            head_data_reg <= TRIT9_ZERO;
            head_pc_reg   <= '0;
        end else begin
            pc_reg        <= pc_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            head_data_reg <= head_data_next;
            head_pc_reg   <= head_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_data;
            pc_mem[wr_ptr_reg]   <= pc_reg;
        end
    end

    assign imem_addr   = pc_reg;
    assign instr_valid = (count_reg != '0);
    assign instr_data  = head_data_reg;
    assign instr_pc    = head_pc_reg;
    assign fifo_count  = count_reg;
endmodule

// File: tb/tb_ternary_fetch_unit.sv
// Randomized bench for ternary_fetch_unit against a queue-based fetch model,
// plus directed scenarios with hand-computed expectations.
module tb_ternary_fetch_unit;
    import ternary_pkg::*;

    localparam int DEPTH = 243;
    localparam int FD    = 4;
    localparam int RPC   = 0;

    typedef struct {
        int     pc;
        trit9_t data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    trit8_t      imem_addr;
    trit9_t      imem_data;
    logic        redirect_valid = 1'b0;
    trit8_t      redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    trit9_t      instr_data;
    trit8_t      instr_pc;
    logic [2:0]  fifo_count;

    trit9_t      imem_words [DEPTH];
    ent_t        mq [$];
    int          mpc;
    int          tests = 0;
    int          fails = 0;
    logic        chk_en = 1'b0;
    int          addr_idx;

    ternary_fetch_unit #(.IMEM_DEPTH(DEPTH), .FIFO_DEPTH(FD), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_pc(instr_pc), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic int t2i(input trit8_t t);
        int acc;
        int w;
        acc = 0;
        w   = 1;
        for (int i = 0; i < 8; i++) begin
            if (t[i] == T_POS_ONE) acc += w;
            else if (t[i] == T_NEG_ONE) acc -= w;
            w *= 3;
        end
        return acc;
    endfunction

    function automatic trit9_t i2t9(input int v);
        trit9_t t;
        int     x;
        int     r;
        x = v;
        for (int i = 0; i < 9; i++) begin
            r = ((x % 3) + 3) % 3;
            t[i] = (r == 0) ? T_ZERO : (r == 1) ? T_POS_ONE : T_NEG_ONE;
            x = (r == 2) ? (x + 1) / 3 : (x - r) / 3;
        end
        return t;
    endfunction

    function automatic trit8_t i2t8(input int v);
        trit9_t t9;
        t9 = i2t9(v);
        return t9[7:0];
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    always_comb begin
        addr_idx  = t2i(imem_addr);
        imem_data = (addr_idx >= 0 && addr_idx < DEPTH) ? imem_words[addr_idx] : '0;
    end

    // Reference model: an integer PC and a queue of fetched (pc, word) pairs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpc = RPC;
        end else begin
            automatic bit do_pop = (mq.size() != 0) && instr_ready;
            automatic int rv;
            if (redirect_valid) begin
                rv = t2i(redirect_pc);
                mq.delete();
                mpc = (rv >= 0 && rv < DEPTH) ? rv : 0;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (fetch_en && (mq.size() < FD)) begin
                    mq.push_back('{pc: mpc, data: imem_words[mpc]});
                    mpc = (mpc + 1) % DEPTH;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("addr", int'(imem_addr), int'(i2t8(mpc)));
            check("valid", int'(instr_valid), int'(mq.size() != 0));
            check("count", int'(fifo_count), mq.size());
            if (mq.size() != 0) begin
                check("head_pc", int'(instr_pc), int'(i2t8(mq[0].pc)));
                check("head_data", int'(instr_data), int'(mq[0].data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fe, input logic rdy, input logic rv, input int rpc);
        fetch_en       = fe;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = i2t8(rpc);
    endtask

    initial begin
        trit8_t t;
        for (int k = 0; k < DEPTH; k++) imem_words[k] = i2t9(k * 37 - 4000);

        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", t2i(imem_addr), RPC);
        check("rst_valid", int'(instr_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_data", int'(instr_data), 0);
        check("rst_pc", int'(instr_pc), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        drive(1, 1, 0, 0);
        tick();
        check("first_pc", t2i(instr_pc), 0);
        check("first_valid", int'(instr_valid), 1);
        check("first_data", int'(instr_data), int'(imem_words[0]));
        repeat (8) tick();

        drive(0, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("fill_count", int'(fifo_count), (k < 4) ? k : 4);
        end
        check("stall_pc", t2i(imem_addr), 4);
        drive(1, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        check("popush_count", int'(fifo_count), 4);
        check("popush_pc", t2i(imem_addr), 5);
        check("popush_head", t2i(instr_pc), 1);

        drive(1, 1, 1, 241);
        tick();
        check("rd241_valid", int'(instr_valid), 0);
        drive(1, 1, 0, 0);
        tick();
        check("wrap_241", t2i(instr_pc), 241);
        tick();
        t = {T_ZERO, T_ZERO, T_POS_ONE, T_ZERO, T_ZERO, T_ZERO, T_ZERO, T_NEG_ONE};
        check("wrap_242_trits", int'(instr_pc), int'(t));
        tick();
        check("wrap_0_trits", int'(instr_pc), 0);

        drive(0, 0, 1, 10);
        tick();
        drive(1, 0, 0, 0);
        repeat (3) tick();
        check("pre_flush_count", int'(fifo_count), 3);
        drive(1, 1, 1, 100);
        tick();
        check("flush_valid", int'(instr_valid), 0);
        check("flush_count", int'(fifo_count), 0);
        drive(1, 1, 0, 0);
        tick();
        check("redir_100", t2i(instr_pc), 100);
        tick();
        check("redir_101", t2i(instr_pc), 101);

        drive(1, 1, 1, -5);
        tick();
        drive(1, 1, 0, 0);
        tick();
        check("redir_neg5", t2i(instr_pc), 0);
        drive(1, 1, 1, 300);
        tick();
        drive(1, 1, 0, 0);
        tick();
        check("redir_300", t2i(instr_pc), 0);
        drive(1, 1, 1, 7);
        redirect_pc[7] = 2'b11;
        tick();
        drive(1, 1, 0, 0);
        tick();
        check("redir_badtrit", t2i(instr_pc), 7);

        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
                  int'($urandom_range(800)) - 400);
            if ($urandom % 4 == 0) redirect_pc[$urandom % 8] = 2'b11;
            tick();
        end

        drive(0, 0, 1, 50);
        tick();
        drive(1, 0, 0, 0);
        repeat (2) tick();
        check("pre_rst_count", int'(fifo_count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", int'(instr_valid), 0);
        check("async_count", int'(fifo_count), 0);
        drive(1, 1, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("restart_pc", t2i(instr_pc), RPC);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
